// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, error-bit positions and framer state type.
// Also used by the transmit FCS path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam int ERR_CRC = 0;
  localparam int ERR_LEN = 1;
  localparam int ERR_PHY = 2;

  // FCS bytes held back so they never reach the packet layer
  localparam int DLY_DEPTH = 5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_PRE,
    RX_DATA,
    RX_DROP
  } rx_state_e;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-parallel CRC-32 next-state, LSB-first (reflected) bit order as sent on the wire.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = bitrev32(CRC32_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? POLY_R : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, forwards the
// frame body five bytes behind the wire and keeps good/bad frame counters.
module gmii_rx_frame
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxerr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_good,
  output logic [2:0]  rx_err,
  output logic [15:0] rx_len,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt
);

  localparam logic [15:0] MIN_L  = MIN_LEN[15:0];
  localparam logic [15:0] MAX_L  = MAX_LEN[15:0];
  localparam logic [15:0] N_SAT  = 16'hFFFF;
  localparam logic [15:0] N_FULL = 16'(DLY_DEPTH);

  rx_state_e state_q, state_d;
  logic      dv_q;
  logic [31:0] crc_q, crc_d, crc_nxt;
  logic [15:0] n_q, n_d;
  logic        phy_q, phy_d;
  logic [DLY_DEPTH-1:0][7:0] dly_q, dly_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, good_q, good_d;
  logic [2:0]  err_q, err_d, frame_err;
  logic [15:0] len_q, len_d;
  logic [31:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic        drop_evt;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_nxt)
  );

  // Register is LSB-first; the residue constant is in polynomial (MSB-first) order.
  always_comb begin
    frame_err          = '0;
    frame_err[ERR_CRC] = (bitrev32(crc_q) != CRC32_RESIDUE);
    frame_err[ERR_LEN] = (n_q < MIN_L) || (n_q > MAX_L);
    frame_err[ERR_PHY] = phy_q;
  end

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    n_d      = n_q;
    phy_d    = phy_q;
    dly_d    = dly_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    good_d   = good_q;
    err_d    = err_q;
    len_d    = len_q;
    drop_evt = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        // dv_q high here means we woke up inside a frame (e.g. after reset)
        if (gmii_rxdv) begin
          if (!dv_q && gmii_rxd == ETH_PREAMBLE) begin
            state_d = RX_PRE;
          end else begin
            state_d  = RX_DROP;
            drop_evt = 1'b1;
          end
        end
      end
      RX_PRE: begin
        if (!gmii_rxdv) begin
          state_d = RX_IDLE;
        end else if (gmii_rxd == ETH_SFD) begin
          state_d = RX_DATA;
          crc_d   = CRC32_INIT;
          n_d     = '0;
          phy_d   = 1'b0;
        end else if (gmii_rxd != ETH_PREAMBLE) begin
          state_d  = RX_DROP;
          drop_evt = 1'b1;
        end
      end
      RX_DATA: begin
        if (n_q >= N_FULL) begin
          valid_d = 1'b1;
          data_d  = dly_q[DLY_DEPTH-1];
          sop_d   = (n_q == N_FULL);
        end
        if (gmii_rxdv) begin
          crc_d = crc_nxt;
          dly_d = {dly_q[DLY_DEPTH-2:0], gmii_rxd};
          if (n_q != N_SAT) n_d = n_q + 16'd1;
          if (gmii_rxerr) phy_d = 1'b1;
        end else begin
          state_d = RX_IDLE;
          if (n_q >= N_FULL) begin
            eop_d  = 1'b1;
            good_d = (frame_err == 3'b000);
            err_d  = frame_err;
            len_d  = (n_q == N_SAT) ? N_SAT : n_q - 16'd4;
          end else begin
            drop_evt = 1'b1;
          end
        end
      end
      RX_DROP: begin
        if (!gmii_rxdv) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A drop and a bad rx_eop can land on the same cycle, so both are summed.
  always_comb begin
    good_cnt_d = good_cnt_q + {31'd0, eop_q & good_q};
    bad_cnt_d  = bad_cnt_q + {31'd0, eop_q & ~good_q} + {31'd0, drop_evt};
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      dv_q       <= 1'b1;
      crc_q      <= CRC32_INIT;
      n_q        <= '0;
      phy_q      <= 1'b0;
      dly_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      good_q     <= 1'b0;
      err_q      <= '0;
      len_q      <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dv_q       <= gmii_rxdv;
      crc_q      <= crc_d;
      n_q        <= n_d;
      phy_q      <= phy_d;
      dly_q      <= dly_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      good_q     <= good_d;
      err_q      <= err_d;
      len_q      <= len_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_sop   = sop_q;
  assign rx_eop   = eop_q;
  assign rx_good  = good_q;
  assign rx_err   = err_q;
  assign rx_len   = len_q;
  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Directed bench for gmii_rx_frame: a table of frames plus back-to-back,
// false-carrier and mid-frame reset sequences.
module tb_gmii_rx_frame;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst, rxdv, rxerr;
  logic [7:0]  rxd;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sop, rx_eop, rx_good;
  logic [2:0]  rx_err;
  logic [15:0] rx_len;
  logic [31:0] good_cnt, bad_cnt;

  gmii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .gmii_rx_clk (clk),
    .rst         (rst),
    .gmii_rxd    (rxd),
    .gmii_rxdv   (rxdv),
    .gmii_rxerr  (rxerr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_sop      (rx_sop),
    .rx_eop      (rx_eop),
    .rx_good     (rx_good),
    .rx_err      (rx_err),
    .rx_len      (rx_len),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- output monitor ----
  logic [7:0] got_q[$];
  int sop_idx[$], eop_idx[$], sop_cyc[$], eop_cyc[$];
  logic       eg = 1'b0;
  logic [2:0] ee = '0;
  logic [15:0] el = '0;
  logic rst_d = 1'b0;
  logic [31:0] snap_out = '1, snap_cnt = '1;
  int snap_eops = 0;

  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    if (rx_sop) begin sop_idx.push_back(got_q.size()); sop_cyc.push_back(cyc); end
    if (rx_eop) begin
      eop_idx.push_back(got_q.size()); eop_cyc.push_back(cyc);
      eg = rx_good; ee = rx_err; el = rx_len;
    end
    if (rx_valid) got_q.push_back(rx_data);
    if (rst_d) begin
      snap_out  = {3'd0, rx_valid, rx_sop, rx_eop, rx_good, rx_err, rx_len, rx_data};
      snap_cnt  = good_cnt | bad_cnt;
      snap_eops = eop_idx.size();
    end
  end

  task automatic clear_mon();
    got_q.delete(); sop_idx.delete(); eop_idx.delete(); sop_cyc.delete(); eop_cyc.delete();
  endtask

  // ---- frame construction ----
  logic [7:0] tx_q[$], exp_q[$];
  int da_idx, t0, tN;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  // kind: 0 normal preamble, 1 second preamble byte is 0x5A, 2 SFD as first byte
  task automatic build(input int pre_len, input int kind, input int body, input int seed,
                       input bit corrupt);
    logic [31:0] c;
    tx_q.delete(); exp_q.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < body; i++) begin
      exp_q.push_back(8'(i * 37 + seed));
      c = crc_upd(c, exp_q[i]);
    end
    c = ~c;
    if (corrupt) exp_q[10] = exp_q[10] ^ 8'h08;
    if (kind == 2) tx_q.push_back(8'hD5);
    else begin
      for (int i = 0; i < pre_len; i++) tx_q.push_back((kind == 1 && i == 1) ? 8'h5A : 8'h55);
      tx_q.push_back(8'hD5);
    end
    da_idx = tx_q.size();
    foreach (exp_q[i]) tx_q.push_back(exp_q[i]);
    for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input int err_at, input int rst_at);
    for (int i = 0; i < tx_q.size(); i++) begin
      @(posedge clk); #1;
      rxd = tx_q[i]; rxdv = 1'b1; rxerr = (i == err_at); rst = (i == rst_at);
      if (i == da_idx) t0 = cyc;
    end
    @(posedge clk); #1;
    rxdv = 1'b0; rxerr = 1'b0; rst = 1'b0; rxd = 8'h00;
    tN = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int data_errs(input int n);
    int e = 0;
    for (int i = 0; i < n; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  // ---- vector table ----
  typedef struct {
    string      name;
    int         pre_len, kind, body, err_at;
    bit         corrupt;
    int         beats, eops;
    bit         good;
    logic [2:0] err;
    int         len, dg, db;
  } vec_t;

  function automatic vec_t mk(input string name, input int pre_len, input int kind, input int body,
                              input bit corrupt, input int err_at, input int beats, input int eops,
                              input bit good, input logic [2:0] err, input int len,
                              input int dg, input int db);
    vec_t v;
    v.name = name; v.pre_len = pre_len; v.kind = kind; v.body = body; v.corrupt = corrupt;
    v.err_at = err_at; v.beats = beats; v.eops = eops; v.good = good; v.err = err;
    v.len = len; v.dg = dg; v.db = db;
    return v;
  endfunction

  vec_t vt[$];
  logic [31:0] g0, b0, c1, c2;
  logic [7:0] exp_a[$];
  int tn_a;

  initial begin
    rst = 1'b1; rxdv = 1'b0; rxerr = 1'b0; rxd = 8'h00;

    //               name       pre kd body cor err beats eop good err     len  dg db
    vt.push_back(mk("good64",    7, 0,  60, 0, -1,   60, 1, 1, 3'b000,   60, 1, 0));
    vt.push_back(mk("badfcs",    7, 0,  60, 1, -1,   60, 1, 0, 3'b001,   60, 0, 1));
    vt.push_back(mk("phyerr",    7, 0,  60, 0, 20,   60, 1, 0, 3'b100,   60, 0, 1));
    vt.push_back(mk("runt60",    7, 0,  56, 0, -1,   56, 1, 0, 3'b010,   56, 0, 1));
    vt.push_back(mk("max1518",   7, 0,1514, 0, -1, 1514, 1, 1, 3'b000, 1514, 1, 0));
    vt.push_back(mk("over1519",  7, 0,1515, 0, -1, 1515, 1, 0, 3'b010, 1515, 0, 1));
    vt.push_back(mk("shortpre",  1, 0,  60, 0, -1,   60, 1, 1, 3'b000,   60, 1, 0));
    vt.push_back(mk("badpre",    7, 1,  60, 0, -1,    0, 0, 0, 3'b000,    0, 0, 1));
    vt.push_back(mk("sfdfirst",  0, 2,  60, 0, -1,    0, 0, 0, 3'b000,    0, 0, 1));
    vt.push_back(mk("n5",        7, 0,   1, 0, -1,    1, 1, 0, 3'b010,    1, 0, 1));
    vt.push_back(mk("n4",        7, 0,   0, 0, -1,    0, 0, 0, 3'b000,    0, 0, 1));

    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_sopeop", {rx_sop, rx_eop}, 0);
    check("rst_status", {rx_good, rx_err, rx_len, rx_data}, 0);
    check("rst_good_cnt", good_cnt, 0);
    check("rst_bad_cnt", bad_cnt, 0);

    // false carrier: rxerr without rxdv is ignored
    b0 = bad_cnt;
    rxerr = 1'b1; rxd = 8'hEE;
    idle(3);
    rxerr = 1'b0; rxd = 8'h00;
    idle(3);
    check("fc_bad_cnt", bad_cnt, b0);
    check("fc_good_cnt", good_cnt, 0);

    foreach (vt[k]) begin
      build(vt[k].pre_len, vt[k].kind, vt[k].body, k + 3, vt[k].corrupt);
      clear_mon();
      g0 = good_cnt; b0 = bad_cnt;
      drive(vt[k].err_at >= 0 ? da_idx + vt[k].err_at : -1, -1);
      @(negedge clk);
      @(negedge clk); c1 = good_cnt + bad_cnt;
      @(negedge clk); c2 = good_cnt + bad_cnt;
      idle(4);
      check({vt[k].name, "_beats"}, got_q.size(), vt[k].beats);
      check({vt[k].name, "_sops"}, sop_idx.size(), vt[k].beats > 0);
      check({vt[k].name, "_eops"}, eop_idx.size(), vt[k].eops);
      if (vt[k].beats > 0) begin
        check({vt[k].name, "_data"}, data_errs(vt[k].beats), 0);
        check({vt[k].name, "_sop_idx"}, sop_idx.size() > 0 ? sop_idx[0] : -1, 0);
        check({vt[k].name, "_sop_cyc"}, sop_cyc.size() > 0 ? sop_cyc[0] : -1, t0 + 6);
      end
      if (vt[k].eops > 0) begin
        check({vt[k].name, "_eop_idx"}, eop_idx.size() > 0 ? eop_idx[0] : -1, vt[k].beats - 1);
        check({vt[k].name, "_eop_cyc"}, eop_cyc.size() > 0 ? eop_cyc[0] : -1, tN + 1);
        check({vt[k].name, "_good"}, eg, vt[k].good);
        check({vt[k].name, "_err"}, ee, vt[k].err);
        check({vt[k].name, "_len"}, el, vt[k].len);
        check({vt[k].name, "_held"}, {rx_good, rx_err}, {vt[k].good, vt[k].err});
        check({vt[k].name, "_cnt_t1"}, c1, g0 + b0);
        check({vt[k].name, "_cnt_t2"}, c2, g0 + b0 + 1);
      end
      check({vt[k].name, "_dgood"}, good_cnt - g0, vt[k].dg);
      check({vt[k].name, "_dbad"}, bad_cnt - b0, vt[k].db);
    end

    // back-to-back frames with a single idle cycle between them
    clear_mon();
    g0 = good_cnt; b0 = bad_cnt;
    build(7, 0, 60, 41, 1'b0);
    exp_a = exp_q;
    drive(-1, -1);
    tn_a = tN;
    build(7, 0, 60, 99, 1'b0);
    drive(-1, -1);
    idle(6);
    exp_q = {exp_a, exp_q};
    check("b2b_beats", got_q.size(), 120);
    check("b2b_data", data_errs(120), 0);
    check("b2b_eops", eop_idx.size(), 2);
    check("b2b_sops", sop_idx.size(), 2);
    check("b2b_eop0_cyc", eop_cyc.size() > 0 ? eop_cyc[0] : -1, tn_a + 1);
    check("b2b_no_overlap", (sop_cyc.size() > 1 && eop_cyc.size() > 0) ? (sop_cyc[1] > eop_cyc[0]) : 0, 1);
    check("b2b_dgood", good_cnt - g0, 2);
    check("b2b_dbad", bad_cnt - b0, 0);

    // reset on payload byte 30 with rxdv held high through the tail
    build(7, 0, 60, 17, 1'b0);
    clear_mon();
    drive(-1, da_idx + 30);
    idle(6);
    check("mrst_outs", snap_out, 0);
    check("mrst_cnts", snap_cnt, 0);
    check("mrst_no_eop", eop_idx.size() - snap_eops, 0);
    check("mrst_bad_cnt", bad_cnt, 1);
    check("mrst_good_cnt", good_cnt, 0);

    build(7, 0, 60, 23, 1'b0);
    clear_mon();
    drive(-1, -1);
    idle(6);
    check("post_rst_beats", got_q.size(), 60);
    check("post_rst_data", data_errs(60), 0);
    check("post_rst_good", {eg, ee}, {1'b1, 3'b000});
    check("post_rst_good_cnt", good_cnt, 1);
    check("post_rst_bad_cnt", bad_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
